axi_mem_arbiter: RTL and testbench
==================================

Name: axi_mem_arbiter

Overview:
- Two-master, one-slave AXI-lite arbiter; lets uart_debug (m0) and a second requester (m1, e.g. a display/DMA reader) share one memory slave (bram_axi or sram_axi).
- Read and write paths are arbitrated independently. Each path allows one outstanding transaction and uses round-robin grant.
- Pure routing/sequencing: no data buffering; all payload muxing is combinational from registered grant state.

Parameters:
ADDR_W, 18, address width (word address into memory)
DATA_W, 16, data width; strobe width is DATA_W/8

Ports:
clk  in  1  clock
reset_  in  1  asynchronous, active-low reset
Identical set per master N in {0,1}; each line also lists the slave-side twin s_* (opposite direction, same width).
mN_ar_addr in ADDR_W / s_ar_addr out: read address
mN_ar_valid in 1 / s_ar_valid out: read address valid
mN_ar_ready out 1 / s_ar_ready in: read address ready
mN_r_data out DATA_W / s_r_data in: read data
mN_r_resp out 2 / s_r_resp in: read response
mN_r_valid out 1 / s_r_valid in: read data valid
mN_r_ready in 1 / s_r_ready out: read data ready
mN_aw_addr in ADDR_W / s_aw_addr out: write address
mN_aw_valid in 1 / s_aw_valid out; mN_aw_ready out 1 / s_aw_ready in
mN_w_data in DATA_W / s_w_data out; mN_w_strb in DATA_W/8 / s_w_strb out
mN_w_valid in 1 / s_w_valid out; mN_w_ready out 1 / s_w_ready in
mN_b_resp out 2 / s_b_resp in; mN_b_valid out 1 / s_b_valid in; mN_b_ready in 1 / s_b_ready out

Behaviour:
- Reset (reset_=0, async): both FSMs go to IDLE, and both round-robin pointers favour m0. Every valid/ready output (master and slave side) is 0. Data, address and resp outputs are 0.
- Read FSM: RD_IDLE -> RD_ADDR -> RD_DATA -> RD_IDLE.
  - RD_IDLE: sample mN_ar_valid. If only one master requests, grant it. If both request, grant the pointer's master. Register rd_gnt and move to RD_ADDR. This gives 1 cycle of arbitration latency. No ar handshake happens in IDLE.
  - RD_ADDR: s_ar_* = granted master's ar_*, and granted mN_ar_ready = s_ar_ready. The other master's ar_ready = 0. On s_ar_valid && s_ar_ready, go to RD_DATA.
  - RD_DATA: s_r_* routes to the granted master only, and s_r_ready = granted mN_r_ready. The other master's r_valid = 0. On the r handshake, go to RD_IDLE, and the pointer is set to favour the non-granted master.
- Write FSM: WR_IDLE -> WR_XFER -> WR_RESP -> WR_IDLE.
  - WR_IDLE: the request is mN_aw_valid || mN_w_valid. Arbitration is the same as read, with its own pointer and 1-cycle latency.
  - WR_XFER: forward aw and w of the granted master. Flags aw_done and w_done set on their respective handshakes. Once a flag is set, that channel's s_*_valid and mN_*_ready are forced to 0. When both flags are set, go to WR_RESP. Both handshakes in the same cycle is legal and moves directly to WR_RESP.
  - WR_RESP: route b to the granted master. On the b handshake, go to WR_IDLE, clear the flags and toggle the pointer away from the granted master.
- Read and write FSMs run fully concurrently; a master may own read while the other owns write.
- Non-granted master: all its ready/valid outputs are 0, and its requests are held pending (never dropped).
- A master deasserting valid before its handshake in ADDR/XFER is an AXI violation. Behaviour in that case is unspecified, but the FSM must not leave its state without a handshake.
- No timeouts. A slave that never responds stalls that path indefinitely.
- Reset mid-transaction: outputs drop to 0 immediately (async), and any in-flight beat is abandoned.
- Fairness: under continuous requests from both masters, grants alternate m0, m1, m0, … per path.

Test Plan:
1. Reset: reset_=0 with both masters valid -> all ready/valid outputs 0. Release reset -> first read grant to m0, with s_ar_valid rising 1 cycle after RD_IDLE samples.
2. m0 reads addr 0x00123, slave returns 0xBEEF with resp 0 -> m0_r_data=0xBEEF and m0_r_valid=1. m1_r_valid stays 0 throughout.
3. Both masters issue continuous reads (m0 0x00010, m1 0x00020) for 4 transactions -> s_ar_addr sequence 0x00010, 0x00020, 0x00010, 0x00020.
4. m1 writes 0x00042 with data 0xA55A and strb 2'b11. The slave accepts w 2 cycles before aw -> exactly one write reaches the slave, then one b pulse to m1, after which the write FSM returns to IDLE.
5. Concurrent paths: m0 writes 0x00001 with 0xDEAD while m1 reads 0x00001 -> both proceed in overlapping cycles, with no cross-routing of r or b.
6. reset_ pulsed low during RD_DATA with s_r_valid=1 -> m*_r_valid=0 immediately. After release, a new read from m1 completes normally.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// Two-master / one-slave AXI-lite arbiter with independent round-robin read and write paths.
// One outstanding transaction per path; payload is routed combinationally from the registered grant.
module axi_mem_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset_,
  // master 0
  input  logic [ADDR_W-1:0]   m0_ar_addr,
  input  logic                m0_ar_valid,
  output logic                m0_ar_ready,
  output logic [DATA_W-1:0]   m0_r_data,
  output logic [1:0]          m0_r_resp,
  output logic                m0_r_valid,
  input  logic                m0_r_ready,
  input  logic [ADDR_W-1:0]   m0_aw_addr,
  input  logic                m0_aw_valid,
  output logic                m0_aw_ready,
  input  logic [DATA_W-1:0]   m0_w_data,
  input  logic [DATA_W/8-1:0] m0_w_strb,
  input  logic                m0_w_valid,
  output logic                m0_w_ready,
  output logic [1:0]          m0_b_resp,
  output logic                m0_b_valid,
  input  logic                m0_b_ready,
  // master 1
  input  logic [ADDR_W-1:0]   m1_ar_addr,
  input  logic                m1_ar_valid,
  output logic                m1_ar_ready,
  output logic [DATA_W-1:0]   m1_r_data,
  output logic [1:0]          m1_r_resp,
  output logic                m1_r_valid,
  input  logic                m1_r_ready,
  input  logic [ADDR_W-1:0]   m1_aw_addr,
  input  logic                m1_aw_valid,
  output logic                m1_aw_ready,
  input  logic [DATA_W-1:0]   m1_w_data,
  input  logic [DATA_W/8-1:0] m1_w_strb,
  input  logic                m1_w_valid,
  output logic                m1_w_ready,
  output logic [1:0]          m1_b_resp,
  output logic                m1_b_valid,
  input  logic                m1_b_ready,
  // slave
  output logic [ADDR_W-1:0]   s_ar_addr,
  output logic                s_ar_valid,
  input  logic                s_ar_ready,
  input  logic [DATA_W-1:0]   s_r_data,
  input  logic [1:0]          s_r_resp,
  input  logic                s_r_valid,
  output logic                s_r_ready,
  output logic [ADDR_W-1:0]   s_aw_addr,
  output logic                s_aw_valid,
  input  logic                s_aw_ready,
  output logic [DATA_W-1:0]   s_w_data,
  output logic [DATA_W/8-1:0] s_w_strb,
  output logic                s_w_valid,
  input  logic                s_w_ready,
  input  logic [1:0]          s_b_resp,
  input  logic                s_b_valid,
  output logic                s_b_ready,
  // debug: current FSM states
  output logic [1:0]          rd_state_dbg,
  output logic [1:0]          wr_state_dbg
);

  // Handshake rule on every channel: a beat transfers on the rising clk edge where
  // valid and ready are both 1; valid is never withdrawn by this block before that edge.

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_XFER = 2'd1, WR_RESP = 2'd2} wr_state_e;

  rd_state_e rd_state, rd_state_nx;
  wr_state_e wr_state, wr_state_nx;
  logic      rd_gnt, rd_gnt_nx, rd_ptr, rd_ptr_nx;   // gnt/ptr: 0 = m0, 1 = m1
  logic      wr_gnt, wr_gnt_nx, wr_ptr, wr_ptr_nx;
  logic      aw_done, aw_done_nx, w_done, w_done_nx;
  logic      wr_req0, wr_req1;

  assign rd_state_dbg = rd_state;
  assign wr_state_dbg = wr_state;
  assign wr_req0      = m0_aw_valid || m0_w_valid;
  assign wr_req1      = m1_aw_valid || m1_w_valid;

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rd_state <= RD_IDLE;
      rd_gnt   <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_state <= WR_IDLE;
      wr_gnt   <= 1'b0;
      wr_ptr   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      rd_state <= rd_state_nx;
      rd_gnt   <= rd_gnt_nx;
      rd_ptr   <= rd_ptr_nx;
      wr_state <= wr_state_nx;
      wr_gnt   <= wr_gnt_nx;
      wr_ptr   <= wr_ptr_nx;
      aw_done  <= aw_done_nx;
      w_done   <= w_done_nx;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    rd_state_nx = rd_state;
    rd_gnt_nx   = rd_gnt;
    rd_ptr_nx   = rd_ptr;
    case (rd_state)
      RD_IDLE: if (m0_ar_valid || m1_ar_valid) begin
        rd_gnt_nx   = (m0_ar_valid && m1_ar_valid) ? rd_ptr : m1_ar_valid;
        rd_state_nx = RD_ADDR;
      end
      RD_ADDR: if (s_ar_valid && s_ar_ready) rd_state_nx = RD_DATA;
      RD_DATA: if (s_r_valid && s_r_ready) begin
        rd_state_nx = RD_IDLE;
        rd_ptr_nx   = ~rd_gnt;
      end
      default: rd_state_nx = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_nx = wr_state;
    wr_gnt_nx   = wr_gnt;
    wr_ptr_nx   = wr_ptr;
    aw_done_nx  = aw_done;
    w_done_nx   = w_done;
    case (wr_state)
      WR_IDLE: if (wr_req0 || wr_req1) begin
        wr_gnt_nx   = (wr_req0 && wr_req1) ? wr_ptr : wr_req1;
        wr_state_nx = WR_XFER;
      end
      WR_XFER: begin
        // aw and w may complete in either order or together
        aw_done_nx = aw_done || (s_aw_valid && s_aw_ready);
        w_done_nx  = w_done || (s_w_valid && s_w_ready);
        if (aw_done_nx && w_done_nx) wr_state_nx = WR_RESP;
      end
      WR_RESP: if (s_b_valid && s_b_ready) begin
        wr_state_nx = WR_IDLE;
        aw_done_nx  = 1'b0;
        w_done_nx   = 1'b0;
        wr_ptr_nx   = ~wr_gnt;
      end
      default: wr_state_nx = WR_IDLE;
    endcase
  end

  // ---------------- output routing ----------------
  always_comb begin
    s_ar_addr   = '0;
    s_ar_valid  = 1'b0;
    s_r_ready   = 1'b0;
    m0_ar_ready = 1'b0;
    m1_ar_ready = 1'b0;
    m0_r_data   = '0;
    m0_r_resp   = 2'b00;
    m0_r_valid  = 1'b0;
    m1_r_data   = '0;
    m1_r_resp   = 2'b00;
    m1_r_valid  = 1'b0;
    if (rd_state == RD_ADDR) begin
      s_ar_addr   = rd_gnt ? m1_ar_addr : m0_ar_addr;
      s_ar_valid  = rd_gnt ? m1_ar_valid : m0_ar_valid;
      m0_ar_ready = !rd_gnt && s_ar_ready;
      m1_ar_ready = rd_gnt && s_ar_ready;
    end
    if (rd_state == RD_DATA) begin
      s_r_ready = rd_gnt ? m1_r_ready : m0_r_ready;
      if (rd_gnt) begin
        m1_r_data  = s_r_data;
        m1_r_resp  = s_r_resp;
        m1_r_valid = s_r_valid;
      end else begin
        m0_r_data  = s_r_data;
        m0_r_resp  = s_r_resp;
        m0_r_valid = s_r_valid;
      end
    end
  end

  always_comb begin
    s_aw_addr   = '0;
    s_aw_valid  = 1'b0;
    s_w_data    = '0;
    s_w_strb    = '0;
    s_w_valid   = 1'b0;
    s_b_ready   = 1'b0;
    m0_aw_ready = 1'b0;
    m1_aw_ready = 1'b0;
    m0_w_ready  = 1'b0;
    m1_w_ready  = 1'b0;
    m0_b_resp   = 2'b00;
    m0_b_valid  = 1'b0;
    m1_b_resp   = 2'b00;
    m1_b_valid  = 1'b0;
    if (wr_state == WR_XFER) begin
      // a completed channel is muted so the slave sees exactly one beat
      s_aw_addr   = wr_gnt ? m1_aw_addr : m0_aw_addr;
      s_aw_valid  = !aw_done && (wr_gnt ? m1_aw_valid : m0_aw_valid);
      s_w_data    = wr_gnt ? m1_w_data : m0_w_data;
      s_w_strb    = wr_gnt ? m1_w_strb : m0_w_strb;
      s_w_valid   = !w_done && (wr_gnt ? m1_w_valid : m0_w_valid);
      m0_aw_ready = !wr_gnt && !aw_done && s_aw_ready;
      m1_aw_ready = wr_gnt && !aw_done && s_aw_ready;
      m0_w_ready  = !wr_gnt && !w_done && s_w_ready;
      m1_w_ready  = wr_gnt && !w_done && s_w_ready;
    end
    if (wr_state == WR_RESP) begin
      s_b_ready = wr_gnt ? m1_b_ready : m0_b_ready;
      if (wr_gnt) begin
        m1_b_resp  = s_b_resp;
        m1_b_valid = s_b_valid;
      end else begin
        m0_b_resp  = s_b_resp;
        m0_b_valid = s_b_valid;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Bench for axi_mem_arbiter: directed master/slave driver tasks, a negedge monitor
// that scores slave-side and master-side handshakes against expected queues.
module tb_axi_mem_arbiter;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic reset_;
  logic [ADDR_W-1:0] m0_ar_addr, m1_ar_addr, m0_aw_addr, m1_aw_addr, s_ar_addr, s_aw_addr;
  logic [DATA_W-1:0] m0_r_data, m1_r_data, m0_w_data, m1_w_data, s_r_data, s_w_data;
  logic [1:0]        m0_w_strb, m1_w_strb, s_w_strb;
  logic [1:0]        m0_r_resp, m1_r_resp, m0_b_resp, m1_b_resp, s_r_resp, s_b_resp;
  logic m0_ar_valid, m0_ar_ready, m0_r_valid, m0_r_ready, m0_aw_valid, m0_aw_ready;
  logic m0_w_valid, m0_w_ready, m0_b_valid, m0_b_ready;
  logic m1_ar_valid, m1_ar_ready, m1_r_valid, m1_r_ready, m1_aw_valid, m1_aw_ready;
  logic m1_w_valid, m1_w_ready, m1_b_valid, m1_b_ready;
  logic s_ar_valid, s_ar_ready, s_r_valid, s_r_ready, s_aw_valid, s_aw_ready;
  logic s_w_valid, s_w_ready, s_b_valid, s_b_ready;
  logic [1:0] rd_state_dbg, wr_state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit overlap_seen;

  logic [17:0] exp_ar_q[$];
  logic [17:0] exp_aw_q[$];
  logic [17:0] exp_w_q[$];   // {data, strb}
  logic [18:0] exp_r_q[$];   // {master, resp, data}
  logic [2:0]  exp_b_q[$];   // {master, resp}
  logic [17:0] e_addr, e_w;
  logic [18:0] e_r;
  logic [2:0]  e_b;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  axi_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset_(reset_),
    .m0_ar_addr(m0_ar_addr), .m0_ar_valid(m0_ar_valid), .m0_ar_ready(m0_ar_ready),
    .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp), .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready),
    .m0_aw_addr(m0_aw_addr), .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready),
    .m0_w_data(m0_w_data), .m0_w_strb(m0_w_strb), .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready),
    .m0_b_resp(m0_b_resp), .m0_b_valid(m0_b_valid), .m0_b_ready(m0_b_ready),
    .m1_ar_addr(m1_ar_addr), .m1_ar_valid(m1_ar_valid), .m1_ar_ready(m1_ar_ready),
    .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp), .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready),
    .m1_aw_addr(m1_aw_addr), .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready),
    .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb), .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready),
    .m1_b_resp(m1_b_resp), .m1_b_valid(m1_b_valid), .m1_b_ready(m1_b_ready),
    .s_ar_addr(s_ar_addr), .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
    .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_valid(s_r_valid), .s_r_ready(s_r_ready),
    .s_aw_addr(s_aw_addr), .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready),
    .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
    .s_b_resp(s_b_resp), .s_b_valid(s_b_valid), .s_b_ready(s_b_ready),
    .rd_state_dbg(rd_state_dbg), .wr_state_dbg(wr_state_dbg)
  );

  // ---------------- scoreboard monitor ----------------
  // Inputs settle by negedge+2; a valid&ready pair seen here transfers at the next posedge.
  always @(negedge clk) begin
    #4;
    if (reset_ === 1'b1) begin
      if (rd_state_dbg != 2'd0 && wr_state_dbg != 2'd0) overlap_seen = 1'b1;
      if (s_ar_valid && s_ar_ready) begin
        n_checks++;
        if (exp_ar_q.size() == 0) begin
          n_fail++; $display("FAIL ar_extra: got addr %h, expected no ar beat", s_ar_addr);
        end else begin
          e_addr = exp_ar_q.pop_front();
          if (s_ar_addr !== e_addr) begin n_fail++; $display("FAIL ar_addr: got %h expected %h", s_ar_addr, e_addr); end
        end
      end
      if (s_aw_valid && s_aw_ready) begin
        n_checks++;
        if (exp_aw_q.size() == 0) begin
          n_fail++; $display("FAIL aw_extra: got addr %h, expected no aw beat", s_aw_addr);
        end else begin
          e_addr = exp_aw_q.pop_front();
          if (s_aw_addr !== e_addr) begin n_fail++; $display("FAIL aw_addr: got %h expected %h", s_aw_addr, e_addr); end
        end
      end
      if (s_w_valid && s_w_ready) begin
        n_checks++;
        if (exp_w_q.size() == 0) begin
          n_fail++; $display("FAIL w_extra: got %h/%b, expected no w beat", s_w_data, s_w_strb);
        end else begin
          e_w = exp_w_q.pop_front();
          if ({s_w_data, s_w_strb} !== e_w) begin n_fail++; $display("FAIL w_beat: got %h expected %h", {s_w_data, s_w_strb}, e_w); end
        end
      end
      if ((m0_r_valid && m0_r_ready) || (m1_r_valid && m1_r_ready)) begin
        n_checks++;
        if (exp_r_q.size() == 0) begin
          n_fail++; $display("FAIL r_extra: m0_r_valid %b m1_r_valid %b, expected none", m0_r_valid, m1_r_valid);
        end else begin
          e_r = exp_r_q.pop_front();
          if (m0_r_valid && m0_r_ready && m1_r_valid && m1_r_ready) begin
            n_fail++; $display("FAIL r_both: both masters got r, expected only m%0d", e_r[18]);
          end else if (m1_r_valid && m1_r_ready ? ({1'b1, m1_r_resp, m1_r_data} !== e_r) : ({1'b0, m0_r_resp, m0_r_data} !== e_r)) begin
            n_fail++;
            $display("FAIL r_beat: got m%0d resp %b data %h expected m%0d resp %b data %h", m1_r_valid && m1_r_ready,
                     m1_r_valid ? m1_r_resp : m0_r_resp, m1_r_valid ? m1_r_data : m0_r_data, e_r[18], e_r[17:16], e_r[15:0]);
          end
        end
      end
      if ((m0_b_valid && m0_b_ready) || (m1_b_valid && m1_b_ready)) begin
        n_checks++;
        if (exp_b_q.size() == 0) begin
          n_fail++; $display("FAIL b_extra: m0_b_valid %b m1_b_valid %b, expected none", m0_b_valid, m1_b_valid);
        end else begin
          e_b = exp_b_q.pop_front();
          if (m0_b_valid && m0_b_ready && m1_b_valid && m1_b_ready) begin
            n_fail++; $display("FAIL b_both: both masters got b, expected only m%0d", e_b[2]);
          end else if (m1_b_valid && m1_b_ready ? ({1'b1, m1_b_resp} !== e_b) : ({1'b0, m0_b_resp} !== e_b)) begin
            n_fail++;
            $display("FAIL b_beat: got m%0d resp %b expected m%0d resp %b", m1_b_valid && m1_b_ready,
                     m1_b_valid ? m1_b_resp : m0_b_resp, e_b[2], e_b[1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    {m0_ar_addr, m1_ar_addr, m0_aw_addr, m1_aw_addr} = '0;
    {m0_w_data, m1_w_data, m0_w_strb, m1_w_strb} = '0;
    {m0_ar_valid, m0_r_ready, m0_aw_valid, m0_w_valid, m0_b_ready} = '0;
    {m1_ar_valid, m1_r_ready, m1_aw_valid, m1_w_valid, m1_b_ready} = '0;
    {s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_aw_ready, s_w_ready, s_b_valid, s_b_resp} = '0;
  endtask

  // One read by master m; keep holds ar_valid high afterwards (continuous requester).
  task automatic rd_txn(input int m, input logic [17:0] addr, input logic [15:0] data,
                        input logic [1:0] resp, input bit keep, input int r_delay);
    bit got = 1'b0;
    logic [1:0] oh = (m == 0) ? 2'b01 : 2'b10;
    exp_ar_q.push_back(addr);
    exp_r_q.push_back({m[0], resp, data});
    if (m == 0) begin m0_ar_addr = addr; m0_ar_valid = 1'b1; end
    else        begin m1_ar_addr = addr; m1_ar_valid = 1'b1; end
    #1;
    for (int i = 0; i < 20; i++) begin
      if (s_ar_valid) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL rd_grant_timeout: s_ar_valid %b after 20 cycles, expected 1", s_ar_valid);
      m0_ar_valid = 1'b0; m1_ar_valid = 1'b0;
      return;
    end
    s_ar_ready = 1'b1; #1;
    n_checks++;
    if ({m1_ar_ready, m0_ar_ready} !== oh) begin
      n_fail++; $display("FAIL rd_ar_ready_route: got %b expected %b", {m1_ar_ready, m0_ar_ready}, oh);
    end
    @(negedge clk);
    s_ar_ready = 1'b0;
    if (!keep) begin if (m == 0) m0_ar_valid = 1'b0; else m1_ar_valid = 1'b0; end
    repeat (r_delay) @(negedge clk);
    s_r_valid = 1'b1; s_r_data = data; s_r_resp = resp;
    m0_r_ready = 1'b1; m1_r_ready = 1'b1;
    #1;
    n_checks++;
    if ({m1_r_valid, m0_r_valid, s_r_ready} !== {oh, 1'b1}) begin
      n_fail++; $display("FAIL rd_r_route: got {m1,m0,s_r_ready}=%b expected %b", {m1_r_valid, m0_r_valid, s_r_ready}, {oh, 1'b1});
    end
    @(negedge clk);
    s_r_valid = 1'b0; s_r_data = '0; s_r_resp = 2'b00;
    m0_r_ready = 1'b0; m1_r_ready = 1'b0;
  endtask

  // One write by master m; slave raises aw/w ready after the given delays and holds them.
  task automatic wr_txn(input int m, input logic [17:0] addr, input logic [15:0] data, input logic [1:0] strb,
                        input int aw_delay, input int w_delay, input logic [1:0] bresp);
    bit got = 1'b0;
    int last = (aw_delay > w_delay) ? aw_delay : w_delay;
    logic [1:0] oh = (m == 0) ? 2'b01 : 2'b10;
    logic [5:0] exp_v;
    exp_aw_q.push_back(addr);
    exp_w_q.push_back({data, strb});
    exp_b_q.push_back({m[0], bresp});
    if (m == 0) begin m0_aw_addr = addr; m0_w_data = data; m0_w_strb = strb; m0_aw_valid = 1'b1; m0_w_valid = 1'b1; end
    else        begin m1_aw_addr = addr; m1_w_data = data; m1_w_strb = strb; m1_aw_valid = 1'b1; m1_w_valid = 1'b1; end
    #1;
    for (int i = 0; i < 20; i++) begin
      if (s_aw_valid || s_w_valid) begin got = 1'b1; break; end
      @(negedge clk); #1;
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL wr_grant_timeout: s_aw_valid %b s_w_valid %b after 20 cycles", s_aw_valid, s_w_valid);
      {m0_aw_valid, m0_w_valid, m1_aw_valid, m1_w_valid} = '0;
      return;
    end
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      s_aw_ready = (c >= aw_delay);
      s_w_ready  = (c >= w_delay);
      #1;
      exp_v = {c <= aw_delay, c <= w_delay, (c == aw_delay) ? oh : 2'b00, (c == w_delay) ? oh : 2'b00};
      n_checks++;
      if ({s_aw_valid, s_w_valid, m1_aw_ready, m0_aw_ready, m1_w_ready, m0_w_ready} !== exp_v) begin
        n_fail++;
        $display("FAIL wr_xfer c=%0d: got {s_aw_v,s_w_v,aw_rdy,w_rdy}=%b expected %b", c,
                 {s_aw_valid, s_w_valid, m1_aw_ready, m0_aw_ready, m1_w_ready, m0_w_ready}, exp_v);
      end
    end
    @(negedge clk);
    s_aw_ready = 1'b0; s_w_ready = 1'b0;
    s_b_valid = 1'b1; s_b_resp = bresp; m0_b_ready = 1'b1; m1_b_ready = 1'b1;
    #1;
    n_checks++;
    if ({s_aw_valid, s_w_valid, m1_b_valid, m0_b_valid, s_b_ready} !== {2'b00, oh, 1'b1}) begin
      n_fail++; $display("FAIL wr_resp_route: got {s_aw_v,s_w_v,b_v,s_b_rdy}=%b expected %b",
                         {s_aw_valid, s_w_valid, m1_b_valid, m0_b_valid, s_b_ready}, {2'b00, oh, 1'b1});
    end
    @(negedge clk);
    s_b_valid = 1'b0; s_b_resp = 2'b00; m0_b_ready = 1'b0; m1_b_ready = 1'b0;
    {m0_aw_valid, m0_w_valid, m1_aw_valid, m1_w_valid} = '0;
    #1;
    n_checks++;
    if (wr_state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL wr_back_to_idle: wr_state %0d expected 0", wr_state_dbg);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset_ = 1'b0;
    m0_ar_valid = 1'b1; m1_ar_valid = 1'b1; m0_ar_addr = 18'h00123; m1_ar_addr = 18'h00456;
    m0_aw_valid = 1'b1; m1_w_valid = 1'b1; m0_r_ready = 1'b1; m1_b_ready = 1'b1;
    m0_aw_addr = 18'h3ABCD; m1_w_data = 16'hFFFF; m1_w_strb = 2'b11;
    s_ar_ready = 1'b1; s_r_valid = 1'b1; s_r_data = 16'hFFFF; s_r_resp = 2'b11;
    s_aw_ready = 1'b1; s_w_ready = 1'b1; s_b_valid = 1'b1; s_b_resp = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({m0_ar_ready, m0_r_valid, m0_aw_ready, m0_w_ready, m0_b_valid, m1_ar_ready, m1_r_valid, m1_aw_ready,
         m1_w_ready, m1_b_valid, s_ar_valid, s_r_ready, s_aw_valid, s_w_valid, s_b_ready} !== 15'd0) begin
      n_fail++; $display("FAIL reset_handshake: some valid/ready output is nonzero, expected all 0");
    end
    n_checks++;
    if ({m0_r_data, m0_r_resp, m0_b_resp, m1_r_data, m1_r_resp, m1_b_resp, s_ar_addr, s_aw_addr, s_w_data, s_w_strb} !== '0) begin
      n_fail++; $display("FAIL reset_payload: s_ar_addr %h s_aw_addr %h s_w_data %h m0_r_data %h, expected all 0",
                         s_ar_addr, s_aw_addr, s_w_data, m0_r_data);
    end
    @(negedge clk);
    {m0_aw_valid, m1_w_valid, m0_r_ready, m1_b_ready} = '0;
    {s_ar_ready, s_r_valid, s_r_data, s_r_resp, s_aw_ready, s_w_ready, s_b_valid, s_b_resp} = '0;
    reset_ = 1'b1;
    #1;
    n_checks++;
    if ({s_ar_valid, rd_state_dbg} !== 3'b0_00) begin
      n_fail++; $display("FAIL first_arb_idle: s_ar_valid %b rd_state %0d expected 0/0", s_ar_valid, rd_state_dbg);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({s_ar_valid, s_ar_addr, s_aw_valid, s_w_valid} !== {1'b1, 18'h00123, 2'b00}) begin
      n_fail++; $display("FAIL first_grant_m0: s_ar_valid %b s_ar_addr %h s_aw/w_valid %b%b expected 1 00123 00",
                         s_ar_valid, s_ar_addr, s_aw_valid, s_w_valid);
    end
  endtask

  task automatic test_single_read();
    rd_txn(0, 18'h00123, 16'hBEEF, 2'b00, 1'b0, 1);
    rd_txn(1, 18'h00456, 16'h1234, 2'b10, 1'b0, 0);   // drains the pending m1 request
  endtask

  task automatic test_rr_reads();
    logic [15:0] d;
    @(negedge clk);
    m0_ar_addr = 18'h00010; m1_ar_addr = 18'h00020;
    m0_ar_valid = 1'b1; m1_ar_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = 16'($urandom_range(0, 16'hFFFF));
      rd_txn(i % 2, (i % 2) ? 18'h00020 : 18'h00010, d, 2'(i), 1'b1, $urandom_range(0, 2));
    end
    m0_ar_valid = 1'b0; m1_ar_valid = 1'b0;
  endtask

  task automatic test_write();
    @(negedge clk);
    wr_txn(1, 18'h00042, 16'hA55A, 2'b11, 2, 0, 2'b00);
    @(negedge clk);
    wr_txn(0, 18'h3FFFF, 16'h0001, 2'b01, 0, 0, 2'b10);
    @(negedge clk); #1;
    n_checks++;
    if ({s_aw_valid, s_w_valid, wr_state_dbg} !== 4'b0) begin
      n_fail++; $display("FAIL wr_no_regrant: s_aw_valid %b s_w_valid %b wr_state %0d expected 0",
                         s_aw_valid, s_w_valid, wr_state_dbg);
    end
  endtask

  task automatic test_concurrent();
    @(negedge clk);
    overlap_seen = 1'b0;
    fork
      wr_txn(0, 18'h00001, 16'hDEAD, 2'b11, 0, 1, 2'b00);
      rd_txn(1, 18'h00001, 16'hC0DE, 2'b00, 1'b0, 1);
    join
    n_checks++;
    if (overlap_seen !== 1'b1) begin
      n_fail++; $display("FAIL concurrent_overlap: overlap %b expected 1", overlap_seen);
    end
  endtask

  task automatic test_reset_mid_read();
    bit got = 1'b0;
    @(negedge clk);
    exp_ar_q.push_back(18'h00077);
    m0_ar_addr = 18'h00077; m0_ar_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (s_ar_valid) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL rst_read_grant_timeout: s_ar_valid %b expected 1", s_ar_valid); end
    s_ar_ready = 1'b1;
    @(negedge clk);
    s_ar_ready = 1'b0; m0_ar_valid = 1'b0;
    s_r_valid = 1'b1; s_r_data = 16'h7777;
    #1;
    n_checks++;
    if (m0_r_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_r_valid: m0_r_valid %b expected 1", m0_r_valid); end
    #1 reset_ = 1'b0;
    #1;
    n_checks++;
    if ({m0_r_valid, m1_r_valid, s_r_ready, m0_r_data, rd_state_dbg} !== '0) begin
      n_fail++; $display("FAIL rst_mid_read: m0_r_valid %b m1_r_valid %b m0_r_data %h rd_state %0d expected 0",
                         m0_r_valid, m1_r_valid, m0_r_data, rd_state_dbg);
    end
    @(negedge clk);
    s_r_valid = 1'b0; s_r_data = '0;
    reset_ = 1'b1;
    rd_txn(1, 18'h00999, 16'h5AA5, 2'b00, 1'b0, 0);
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_rr_reads();
    test_write();
    test_concurrent();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    #5;
    n_checks++;
    if (exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size() + exp_r_q.size() + exp_b_q.size() != 0) begin
      n_fail++; $display("FAIL queues_drained: ar %0d aw %0d w %0d r %0d b %0d left, expected 0", exp_ar_q.size(),
                         exp_aw_q.size(), exp_w_q.size(), exp_r_q.size(), exp_b_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded 200000 time units, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
